alu_4b_arb_seq: RTL and testbench

- Two-requester round-robin arbiter and sequencer that shares one combinational alu_4b between two clients.
- Accepts an operation (op_a, op_b, inst) from one requester through a valid/ready handshake, then drives the ALU operand/instruction inputs from registers.
- Waits a programmable number of settle cycles, captures alu_out, and returns the result tagged with the requester id through a valid/ready response channel.
- Sits between the client datapaths and the alu_4b instance at the same hierarchy level.

---
 rtl/alu_4b_arb_seq.sv | 151 +++++++++++++++
 tb/tb_alu_4b_arb_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_4b_arb_seq.sv
// Round-robin arbiter and sequencer sharing one combinational alu_4b between two requesters.
// Operands are registered onto the ALU, held for EXEC_CYCLES, then the result is returned with its id.
module alu_4b_arb_seq #(
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [3:0]       req0_inst,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [3:0]       req1_inst,

    output logic [3:0]       alu_op_a,
    output logic [3:0]       alu_op_b,
    output logic [3:0]       alu_inst,
    input  logic [3:0]       alu_out,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [3:0]       rsp_data,

    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] ExecLoad = 4'(EXEC_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       exec_cnt_q, exec_cnt_d;
    // Last granted requester; it is also the id of the operation in flight.
    logic             grant_q, grant_d;
    logic [3:0]       op_a_q, op_a_d;
    logic [3:0]       op_b_q, op_b_d;
    logic [3:0]       inst_q, inst_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [3:0]       rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic sel;
    logic accept;

    always_comb begin
        sel = ~grant_q;
        if (req0_valid && !req1_valid) begin
            sel = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            sel = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && !sel;
    assign req1_ready = (state_q == IDLE) && req1_valid && sel;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_d     = state_q;
        exec_cnt_d  = exec_cnt_q;
        grant_d     = grant_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        inst_d      = inst_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_a_d     = sel ? req1_a    : req0_a;
                    op_b_d     = sel ? req1_b    : req0_b;
                    inst_d     = sel ? req1_inst : req0_inst;
                    grant_d    = sel;
                    exec_cnt_d = ExecLoad;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (exec_cnt_q == 4'd0) begin
                    rsp_data_d  = alu_out;
                    rsp_id_d    = grant_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    exec_cnt_d = exec_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            exec_cnt_q  <= 4'd0;
            grant_q     <= 1'b1;
            op_a_q      <= 4'd0;
            op_b_q      <= 4'd0;
            inst_q      <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 4'd0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            exec_cnt_q  <= exec_cnt_d;
            grant_q     <= grant_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            inst_q      <= inst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_op_a  = op_a_q;
    assign alu_op_b  = op_b_q;
    assign alu_inst  = inst_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_4b_arb_seq.sv
// Directed bench: dut_a (EXEC_CYCLES=1, CNT_W=8) and dut_b (EXEC_CYCLES=3, CNT_W=2) with a small ALU model.
module tb_alu_4b_arb_seq;

    logic clk;
    logic rst;

    logic       r0v, r1v, rsp_ready;
    logic [3:0] r0a, r0b, r0i, r1a, r1b, r1i;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic [3:0] alu_op_a, alu_op_b, alu_inst, alu_out, rsp_data;
    logic [7:0] op_count;

    logic       b_r0v, b_r1v, b_rsp_ready;
    logic [3:0] b_r0a, b_r0b, b_r0i, b_r1a, b_r1b, b_r1i;
    logic       b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id, b_busy;
    logic [3:0] b_alu_op_a, b_alu_op_b, b_alu_inst, b_alu_out, b_rsp_data;
    logic [1:0] b_op_count;

    int checks;
    int failures;

    // Stand-in for alu_4b: 0001 OR, 0010 AND, 0011 XOR, 1000 ADD, 1001 SUB.
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] i);
        case (i)
            4'b0001: return a | b;
            4'b0010: return a & b;
            4'b0011: return a ^ b;
            4'b1000: return a + b;
            4'b1001: return a - b;
            default: return 4'h0;
        endcase
    endfunction

    assign alu_out   = alu_model(alu_op_a, alu_op_b, alu_inst);
    assign b_alu_out = alu_model(b_alu_op_a, b_alu_op_b, b_alu_inst);

    alu_4b_arb_seq #(.EXEC_CYCLES(1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0a), .req0_b(r0b), .req0_inst(r0i),
        .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1a), .req1_b(r1b), .req1_inst(r1i),
        .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_inst(alu_inst), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    alu_4b_arb_seq #(.EXEC_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_r0v), .req0_ready(b_req0_ready), .req0_a(b_r0a), .req0_b(b_r0b),
        .req0_inst(b_r0i),
        .req1_valid(b_r1v), .req1_ready(b_req1_ready), .req1_a(b_r1a), .req1_b(b_r1b),
        .req1_inst(b_r1i),
        .alu_op_a(b_alu_op_a), .alu_op_b(b_alu_op_b), .alu_inst(b_alu_inst),
        .alu_out(b_alu_out),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
        .rsp_data(b_rsp_data),
        .busy(b_busy), .op_count(b_op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
        checks++; if (rsp_id !== 1'b0) begin failures++; $display("FAIL reset_rsp_id got %0h want 0", rsp_id); end
        checks++; if (rsp_data !== 4'h0) begin failures++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
        checks++; if ({alu_op_a, alu_op_b, alu_inst} !== 12'h000) begin failures++; $display("FAIL reset_alu_ops got %0h want 000", {alu_op_a, alu_op_b, alu_inst}); end
        checks++; if (op_count !== 8'h00) begin failures++; $display("FAIL reset_op_count got %0h want 0", op_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0h want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        r0v = 1'b1; r0a = 4'b0011; r0b = 4'b0110; r0i = 4'b0010;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        r0v = 1'b0;
        #1;
        checks++; if ({alu_op_a, alu_op_b, alu_inst} !== 12'h362) begin failures++; $display("FAIL single_alu_ops got %0h want 362", {alu_op_a, alu_op_b, alu_inst}); end
        checks++; if ({busy, rsp_valid} !== 2'b10) begin failures++; $display("FAIL single_exec_state got %b want 10", {busy, rsp_valid}); end
        @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_0_0010) begin failures++; $display("FAIL single_rsp got %b want 100010", {rsp_valid, rsp_id, rsp_data}); end
        @(negedge clk);
        #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL single_done got %b want 00", {rsp_valid, busy}); end
        checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL single_op_count got %0d want 1", op_count); end
    endtask

    task automatic test_req1_latency();
        int lat;
        @(negedge clk);
        r1v = 1'b1; r1a = 4'b0110; r1b = 4'b1000; r1i = 4'b1000;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL req1_ready got %b want 01", {req0_ready, req1_ready}); end
        lat = 0;
        do begin
            @(negedge clk);
            r1v = 1'b0;
            lat++;
        end while (!rsp_valid && lat < 20);
        #1;
        checks++; if (lat != 2) begin failures++; $display("FAIL req1_latency got %0d want 2", lat); end
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_1_1110) begin failures++; $display("FAIL req1_rsp got %b want 111110", {rsp_valid, rsp_id, rsp_data}); end
        @(negedge clk);
        #1;
        checks++; if (op_count !== 8'd2) begin failures++; $display("FAIL req1_op_count got %0d want 2", op_count); end
    endtask

    task automatic test_contention();
        int acc, rsp, last_acc, cyc;
        logic exp_g, exp_r;
        logic [3:0] exp_d;
        acc = 0; rsp = 0; last_acc = -1; exp_g = 1'b0; exp_r = 1'b0;
        @(negedge clk);
        // req0: 0101 | 0011 = 0111; req1: 1100 ^ 1010 = 0110
        r0v = 1'b1; r0a = 4'd5;  r0b = 4'd3;  r0i = 4'b0001;
        r1v = 1'b1; r1a = 4'd12; r1b = 4'd10; r1i = 4'b0011;
        for (cyc = 0; cyc < 40 && !(acc == 4 && rsp == 4); cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                checks++; if (req0_ready && req1_ready) begin failures++; $display("FAIL contention_one_ready got 11 want one-hot"); end
                checks++; if (req1_ready !== exp_g) begin failures++; $display("FAIL contention_grant got %0d want %0d", req1_ready, exp_g); end
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 3) begin failures++; $display("FAIL contention_interval got %0d want 3", cyc - last_acc); end
                end
                last_acc = cyc;
                exp_g = ~exp_g;
                acc++;
            end
            if (rsp_valid) begin
                exp_d = exp_r ? 4'b0110 : 4'b0111;
                checks++; if (rsp_id !== exp_r) begin failures++; $display("FAIL contention_rsp_id got %0d want %0d", rsp_id, exp_r); end
                checks++; if (rsp_data !== exp_d) begin failures++; $display("FAIL contention_rsp_data got %b want %b", rsp_data, exp_d); end
                exp_r = ~exp_r;
                rsp++;
            end
            @(negedge clk);
        end
        r0v = 1'b0; r1v = 1'b0;
        #1;
        checks++; if (acc != 4 || rsp != 4) begin failures++; $display("FAIL contention_timeout got acc=%0d rsp=%0d want 4/4", acc, rsp); end
        checks++; if (op_count !== 8'd6) begin failures++; $display("FAIL contention_op_count got %0d want 6", op_count); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        rsp_ready = 1'b0;
        r1v = 1'b1; r1a = 4'd9; r1b = 4'd4; r1i = 4'b1001;
        #1;
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL bp_accept got %0d want 1", req1_ready); end
        @(negedge clk);
        r1v = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_timeout got rsp_valid=%0d want 1", rsp_valid); end
        r0v = 1'b1; r0a = 4'd1; r0b = 4'd1; r0i = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_1_0101) begin failures++; $display("FAIL bp_hold got %b want 110101", {rsp_valid, rsp_id, rsp_data}); end
            checks++; if ({req0_ready, req1_ready, busy} !== 3'b001) begin failures++; $display("FAIL bp_ready_busy got %b want 001", {req0_ready, req1_ready, busy}); end
            @(negedge clk);
        end
        r0v = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got %0d want 0", rsp_valid); end
        checks++; if (op_count !== 8'd7) begin failures++; $display("FAIL bp_op_count got %0d want 7", op_count); end
        @(negedge clk);
        #1;
        checks++; if ({op_count, busy} !== {8'd7, 1'b0}) begin failures++; $display("FAIL bp_once got %0d/%0d want 7/0", op_count, busy); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        r0v = 1'b1; r0a = 4'd7; r0b = 4'd1; r0i = 4'b1000;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got %0d want 1", req0_ready); end
        @(negedge clk);
        r0v = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_exec got busy=%0d want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if ({rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL rmid_clear got %b want 00", {rsp_valid, busy}); end
        checks++; if ({alu_op_a, alu_op_b, alu_inst} !== 12'h000) begin failures++; $display("FAIL rmid_alu_ops got %0h want 000", {alu_op_a, alu_op_b, alu_inst}); end
        checks++; if (op_count !== 8'd0) begin failures++; $display("FAIL rmid_op_count got %0d want 0", op_count); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_rsp got %0d want 0", rsp_valid); end
        r0v = 1'b1; r0a = 4'd2;  r0b = 4'd5;  r0i = 4'b1000;
        r1v = 1'b1; r1a = 4'd15; r1b = 4'd15; r1i = 4'b0010;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL rmid_first_grant got %b want 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        r0v = 1'b0; r1v = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_0_0111) begin failures++; $display("FAIL rmid_rsp got %b want 100111", {rsp_valid, rsp_id, rsp_data}); end
        @(negedge clk);
        #1;
        checks++; if (op_count !== 8'd1) begin failures++; $display("FAIL rmid_op_count_after got %0d want 1", op_count); end
    endtask

    task automatic test_exec3_latency();
        int lat;
        @(negedge clk);
        b_r1v = 1'b1; b_r1a = 4'b0110; b_r1b = 4'b1000; b_r1i = 4'b1000;
        #1;
        checks++; if (b_req1_ready !== 1'b1) begin failures++; $display("FAIL exec3_accept got %0d want 1", b_req1_ready); end
        lat = 0;
        do begin
            @(negedge clk);
            b_r1v = 1'b0;
            lat++;
        end while (!b_rsp_valid && lat < 20);
        #1;
        checks++; if (lat != 4) begin failures++; $display("FAIL exec3_latency got %0d want 4", lat); end
        checks++; if ({b_rsp_id, b_rsp_data} !== 5'b1_1110) begin failures++; $display("FAIL exec3_rsp got %b want 11110", {b_rsp_id, b_rsp_data}); end
        @(negedge clk);
        #1;
        checks++; if (b_op_count !== 2'd1) begin failures++; $display("FAIL exec3_op_count got %0d want 1", b_op_count); end
    endtask

    task automatic test_counter_wrap();
        logic [1:0] exp_cnt [4];
        logic [3:0] exp_d;
        int lat;
        exp_cnt = '{2'd2, 2'd3, 2'd0, 2'd1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_r0v = 1'b1; b_r0a = 4'(k + 1); b_r0b = 4'd1; b_r0i = 4'b1000;
            exp_d = 4'(k + 2);
            lat = 0;
            do begin
                @(negedge clk);
                b_r0v = 1'b0;
                lat++;
            end while (!b_rsp_valid && lat < 20);
            #1;
            checks++; if (b_rsp_data !== exp_d) begin failures++; $display("FAIL wrap_rsp_data got %0d want %0d", b_rsp_data, exp_d); end
            @(negedge clk);
            #1;
            checks++; if (b_op_count !== exp_cnt[k]) begin failures++; $display("FAIL wrap_op_count got %0d want %0d", b_op_count, exp_cnt[k]); end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; rsp_ready = 1'b1; b_rsp_ready = 1'b1;
        r0v = 1'b0; r0a = 4'd0; r0b = 4'd0; r0i = 4'd0;
        r1v = 1'b0; r1a = 4'd0; r1b = 4'd0; r1i = 4'd0;
        b_r0v = 1'b0; b_r0a = 4'd0; b_r0b = 4'd0; b_r0i = 4'd0;
        b_r1v = 1'b0; b_r1a = 4'd0; b_r1b = 4'd0; b_r1i = 4'd0;
        test_reset();
        test_single_op();
        test_req1_latency();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_exec3_latency();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1);
    end

endmodule
